// File: rtl/intercal_alu_seq.sv
// Byte-stream front end for an INTERCAL-style ALU. It collects an opcode and its little-endian
// operands, runs one ALU command, and streams the result (or a 0xEE error byte) back out.
module intercal_alu_seq #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    output logic        out_err,
    input  logic        out_ready,
    output logic [2:0]  alu_op,
    output logic        alu_wide,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [31:0] alu_result,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        EXEC,
        WAIT,
        SEND,
        ERR
    } state_t;

    localparam logic [2:0] OP_MINGLE = 3'b000;
    localparam logic [2:0] OP_SELECT = 3'b001;
    localparam logic [2:0] OP_LAST   = 3'b100;
    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic [2:0]  op_q, op_d;
    logic        wide_q, wide_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] res_q, res_d;
    logic        live_q;

    logic        has_b;
    logic [1:0]  opnd_last;
    logic [1:0]  res_last;

    // Mingle is always 16+16 bits in but 32 bits out, regardless of the wide bit.
    assign has_b     = (op_q == OP_MINGLE) || (op_q == OP_SELECT);
    assign opnd_last = ((op_q == OP_MINGLE) || !wide_q) ? 2'd1 : 2'd3;
    assign res_last  = ((op_q == OP_MINGLE) || wide_q) ? 2'd3 : 2'd1;

    assign alu_op   = op_q;
    assign alu_wide = wide_q;
    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign busy     = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            tcnt_q  <= 8'd0;
            op_q    <= 3'd0;
            wide_q  <= 1'b0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            res_q   <= 32'd0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            op_q    <= op_d;
            wide_q  <= wide_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            live_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tcnt_d    = tcnt_q;
        op_d      = op_q;
        wide_d    = wide_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_err   = 1'b0;
        out_data  = 8'h00;
        alu_start = 1'b0;

        case (state_q)
            IDLE: begin
                // live_q keeps in_ready low until the first edge after reset release.
                in_ready = live_q;
                if (in_valid && live_q) begin
                    op_d    = in_data[2:0];
                    wide_d  = in_data[3];
                    a_d     = 32'd0;
                    b_d     = 32'd0;
                    res_d   = 32'd0;
                    state_d = (in_data[2:0] <= OP_LAST) ? LOAD_A : ERR;
                end
            end
            LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d = a_q | (32'(in_data) << {cnt_q, 3'b000});
                    if (cnt_q == opnd_last) begin
                        state_d = has_b ? LOAD_B : EXEC;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    b_d = b_q | (32'(in_data) << {cnt_q, 3'b000});
                    if (cnt_q == opnd_last) begin
                        state_d = EXEC;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            EXEC: begin
                alu_start = 1'b1;
                tcnt_d    = 8'd0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (alu_done) begin
                    res_d   = alu_result;
                    state_d = SEND;
                end else if (tcnt_q == TO_LAST) begin
                    state_d = ERR;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = res_q[{cnt_q, 3'b000} +: 8];
                out_last  = (cnt_q == res_last);
                if (out_ready) begin
                    if (cnt_q == res_last) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            ERR: begin
                out_valid = 1'b1;
                out_data  = 8'hEE;
                out_err   = 1'b1;
                out_last  = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Every state starts counting bytes from zero.
        if (state_d != state_q) begin
            cnt_d = 2'd0;
        end
    end

endmodule

// File: doc/intercal_alu_seq.md
INTERCAL_ALU_SEQ -- requirements
Module: intercal_alu_seq

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning maximum cycles waited for alu_done after alu_start (range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports in_data input 8 and in_valid input 1: command/operand byte stream.
REQ-005 SHALL have port in_ready  output  1  byte accepted when in_valid and in_ready are both high.
REQ-006 SHALL have ports out_data output 8, out_valid output 1, out_last output 1 (final result byte), out_err output 1 (error byte).
REQ-007 SHALL have port out_ready  input  1  byte consumed when out_valid and out_ready are both high.
REQ-008 SHALL have ports alu_op output 3, alu_wide output 1, alu_a output 32, alu_b output 32, alu_start output 1: ALU command.
REQ-009 SHALL have ports alu_done input 1, alu_result input 32: ALU completion.
REQ-010 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-011 Opcode byte SHALL be bits[2:0] op (000 mingle, 001 select, 010 AND, 011 OR, 100 XOR; 101-111 illegal), bit[3] wide; bits[7:4] ignored.
REQ-012 Operand bytes SHALL arrive little-endian: mingle 2 A + 2 B (wide ignored); select 2+2 (wide=0) or 4+4 (wide=1); unary 2 A (wide=0) or 4 A (wide=1), no B.
REQ-013 Unloaded operand bits SHALL be zero; alu_a/alu_b/alu_op/alu_wide SHALL be held stable from EXEC until the next opcode is accepted.
REQ-014 States SHALL be IDLE, LOAD_A, LOAD_B, EXEC, WAIT, SEND, ERR.
REQ-015 in_ready SHALL be 1 only in IDLE, LOAD_A, LOAD_B.
REQ-016 IDLE: accepted legal opcode -> LOAD_A; accepted illegal opcode -> ERR.
REQ-017 LOAD_A: after last A byte -> LOAD_B if op has B, else EXEC; LOAD_B: after last B byte -> EXEC.
REQ-018 EXEC SHALL last exactly one cycle with alu_start=1, then -> WAIT; alu_start SHALL be 0 in all other states.
REQ-019 WAIT: alu_done sampled from the first WAIT cycle; on alu_done, capture alu_result -> SEND; alu_done in any other state SHALL be ignored.
REQ-020 WAIT: if alu_done absent for TIMEOUT cycles -> ERR.
REQ-021 SEND SHALL emit result little-endian: 4 bytes for mingle and wide ops, 2 bytes for select/unary with wide=0 (result bits[15:0]).
REQ-022 out_data/out_last SHALL be stable while out_valid=1 and out_ready=0; out_last=1 only on final byte; after final handshake -> IDLE.
REQ-023 ERR SHALL present one byte 0xEE with out_err=1, out_last=1; after handshake -> IDLE.
REQ-024 out_err SHALL be 0 in SEND; out_valid SHALL be 0 outside SEND/ERR.
REQ-025 Byte counter SHALL reset to 0 on each state entry; no byte SHALL be skipped or duplicated under arbitrary in_valid/out_ready stalls.
REQ-026 Minimum latency opcode-accept to first out_valid, no stalls, alu_done in first WAIT cycle: operand bytes + 3 cycles.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, clear counters/operands/result, and drive in_ready=0, out_valid=0, out_last=0, out_err=0, out_data=0, alu_start=0, alu_op=0, alu_wide=0, alu_a=0, alu_b=0, busy=0.
REQ-028 in_ready SHALL rise to 1 on the first clk edge after rst_n deasserts.
REQ-029 Reset mid-operation SHALL discard partial operands/results; no output byte SHALL follow from the aborted command.

Verification
REQ-030 Mingle: bytes 00,34,12,78,56 -> alu_op=000, alu_a=00001234, alu_b=00005678, one alu_start pulse; ALU returns 0x12345678 -> out 78,56,34,12, out_last on 12.
REQ-031 Unary XOR wide=0: bytes 04,CD,AB -> alu_a=0000ABCD, no LOAD_B; result 0x0000FFEE -> out EE,FF, out_last on FF, out_err=0.
REQ-032 Illegal opcode 07 -> in_ready low next cycle, out 0xEE with out_err=1, out_last=1, then IDLE; alu_start never asserted.
REQ-033 Timeout: select wide=1 loaded, alu_done held 0 -> error byte 0xEE appears exactly TIMEOUT cycles after first WAIT cycle.
REQ-034 Stalls: random in_valid gaps and out_ready held low 5 cycles per byte on select wide=1 -> identical bytes/order as unstalled run, out_data stable during stalls.
REQ-035 Reset asserted in LOAD_B, then new mingle command -> outputs zero during reset, second command completes correctly with no residue.
